// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg: FSM state encodings and bus width defaults shared by the memory bus master
package mem_bus_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, VERIFY = 2'd2, RESP = 2'd3} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
endpackage

// File: rtl/mem_bus_master_rsp_capture.sv
// mem_rsp_capture: load-enable response data register with synchronous reset
module mem_rsp_capture #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: valid/ready request to single registered memory bus access with one-cycle response; MEM_MASTER_WRITE_VERIFY_EN adds write readback check
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cap_ld;
  logic [DATA_W-1:0] cap_d;
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    mem_cs_d    = mem_cs_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cap_ld      = 1'b0;
    cap_d       = mem_rdata;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          state_d     = ACCESS;
          req_ready_d = 1'b0;
          mem_cs_d    = 1'b1;
          mem_rd_d    = !req_write;
          mem_wr_d    = req_write;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_write ? req_wdata : '0;
        end
      end
      ACCESS: begin
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        if (mem_wr_q) begin
          state_d  = VERIFY;
          mem_wr_d = 1'b0;
          mem_rd_d = 1'b1;
        end else
`endif
        begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = mem_wr_q;
          rsp_err_d   = 1'b0;
          cap_ld      = 1'b1;
          cap_d       = mem_wr_q ? '0 : mem_rdata;
          mem_cs_d    = 1'b0;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
`ifdef MEM_MASTER_WRITE_VERIFY_EN
      VERIFY: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_err_d   = mem_rdata != mem_wdata_q;
        cap_ld      = 1'b1;
        mem_cs_d    = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
`endif
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      mem_cs_q    <= mem_cs_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  mem_rsp_capture #(.W(DATA_W)) u_cap (
    .clk(clk),
    .rst(reset),
    .ld (cap_ld),
    .d  (cap_d),
    .q  (rsp_rdata)
  );
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign mem_cs    = mem_cs_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule
